// File: rtl/riscv_imm_pkg.sv
// Shared opcode constants, immediate-format encodings and sizing helper
// for the decode-stage immediate unit.
package riscv_imm_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_Z    = 3'd5,
        IMM_SH   = 3'd6,
        IMM_NONE = 3'd7
    } imm_type_e;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/riscv_imm_decode.sv
// Combinational instruction -> {immediate, format, illegal} decoder.
// Format is inferred from the opcode; all sign extension is to full XLEN.
module riscv_imm_decode
    import riscv_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_type_e       typ,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [2:0] funct3;
    logic [5:0] shamt;

    assign funct3 = inst[14:12];
    // RV64 shifts use a 6-bit shamt; RV32 ignores inst[25].
    assign shamt  = RV64 ? inst[25:20] : {1'b0, inst[24:20]};

    always_comb begin
        imm     = '0;
        typ     = IMM_NONE;
        illegal = 1'b0;
        if (inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (inst[6:0])
                OPC_LOAD, OPC_JALR: begin
                    typ = IMM_I;
                    imm = XLEN'($signed(inst[31:20]));
                end
                OPC_OP_IMM: begin
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        typ = IMM_SH;
                        imm = XLEN'(shamt);
                    end else begin
                        typ = IMM_I;
                        imm = XLEN'($signed(inst[31:20]));
                    end
                end
                OPC_OP_IMM_32: begin
                    if (!RV64) begin
                        illegal = 1'b1;
                    end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        typ = IMM_SH;
                        imm = XLEN'(inst[24:20]);
                    end else begin
                        typ = IMM_I;
                        imm = XLEN'($signed(inst[31:20]));
                    end
                end
                OPC_STORE: begin
                    typ = IMM_S;
                    imm = XLEN'($signed({inst[31:25], inst[11:7]}));
                end
                OPC_BRANCH: begin
                    typ = IMM_B;
                    imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
                end
                OPC_LUI, OPC_AUIPC: begin
                    typ = IMM_U;
                    imm = XLEN'($signed({inst[31:12], 12'b0}));
                end
                OPC_JAL: begin
                    typ = IMM_J;
                    imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
                end
                OPC_SYSTEM: begin
                    if (funct3[2]) begin
                        typ = IMM_Z;
                        imm = XLEN'(inst[19:15]);
                    end else begin
                        typ = IMM_I;
                        imm = XLEN'($signed(inst[31:20]));
                    end
                end
                OPC_OP, OPC_MISC_MEM: begin
                    typ = IMM_NONE;
                end
                OPC_OP_32: begin
                    illegal = !RV64;
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/riscv_imm_gen_pipe.sv
// Decode-stage immediate unit: decode at push, DEPTH-entry elastic buffer, latency 1.
// Valid/ready on both sides; in_ready drops only when full; flush empties the buffer.
module riscv_imm_gen_pipe
    import riscv_imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_inst,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               imm_out,
    output logic [2:0]                    imm_type,
    output logic                          illegal,
    output logic [TAG_W-1:0]              tag_out,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [XLEN-1:0]  dec_imm;
    imm_type_e        dec_type;
    logic             dec_illegal;

    logic [XLEN-1:0]  imm_mem  [DEPTH];
    logic [2:0]       type_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [DEPTH-1:0] ill_mem;
    logic [DEPTH-1:0] vld;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;
    logic             head_ok;

    riscv_imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (in_inst),
        .imm     (dec_imm),
        .typ     (dec_type),
        .illegal (dec_illegal)
    );

    assign in_ready  = (cnt != CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign count     = cnt;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else begin
            // Push and pop never target the same slot: that needs count 0 or DEPTH.
            if (pop) begin
                rd_ptr      <= rd_ptr + PW'(1);
                vld[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr      <= wr_ptr + PW'(1);
                vld[wr_ptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload needs no reset: it is only observed behind the entry-valid bit.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            imm_mem[wr_ptr]  <= dec_imm;
            type_mem[wr_ptr] <= dec_type;
            tag_mem[wr_ptr]  <= in_tag;
            ill_mem[wr_ptr]  <= dec_illegal;
        end
    end

    assign head_ok  = out_valid && vld[rd_ptr];
    assign imm_out  = head_ok ? imm_mem[rd_ptr]  : '0;
    assign imm_type = head_ok ? type_mem[rd_ptr] : 3'd0;
    assign illegal  = head_ok ? ill_mem[rd_ptr]  : 1'b0;
    assign tag_out  = head_ok ? tag_mem[rd_ptr]  : '0;

endmodule

// File: tb/tb_riscv_imm_gen_pipe.sv
// Directed bench: an XLEN=32 and an XLEN=64 instance share one stimulus stream.
module tb_riscv_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32, tag32;
    logic [2:0]  type32;
    logic [1:0]  count32;

    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    logic [31:0] tag64;
    logic [2:0]  type64;
    logic [1:0]  count64;

    int vectors    = 0;
    int miscompares = 0;

    riscv_imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm_out(imm32), .imm_type(type32), .illegal(illegal32),
        .tag_out(tag32), .count(count32)
    );

    riscv_imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm_out(imm64), .imm_type(type64), .illegal(illegal64),
        .tag_out(tag64), .count(count64)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push one instruction with out_ready=1 while one entry is already held:
    // the old head pops, the new one becomes head, occupancy stays 1.
    task automatic apply(input string name, input logic [31:0] inst, input logic [31:0] tag,
                         input logic [31:0] e32, input logic [2:0] t32, input logic i32,
                         input logic [63:0] e64, input logic [2:0] t64, input logic i64);
        in_valid = 1'b1;
        in_inst  = inst;
        in_tag   = tag;
        tick();
        chk({name, ".valid"}, out_valid32, 1);
        chk({name, ".count"}, count32, 1);
        chk({name, ".imm32"}, imm32, e32);
        chk({name, ".type32"}, type32, t32);
        chk({name, ".ill32"}, illegal32, i32);
        chk({name, ".tag"}, tag32, tag);
        chk({name, ".imm64"}, imm64, e64);
        chk({name, ".type64"}, type64, t64);
        chk({name, ".ill64"}, illegal64, i64);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_tag    = 32'h0;
        out_ready = 1'b0;
        #12;
        chk("rst.count", count32, 0);
        chk("rst.out_valid", out_valid32, 0);
        chk("rst.in_ready", in_ready32, 1);
        chk("rst.imm", imm32, 0);
        chk("rst.tag", tag32, 0);
        rst = 1'b0;
        tick();

        // Decode coverage, streaming with out_ready=1
        out_ready = 1'b1;
        apply("addi",   32'hFFF00093, 32'd1,  32'hFFFFFFFF, 3'd0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0);
        apply("sw",     32'hFE112E23, 32'd2,  32'hFFFFFFFC, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0);
        apply("beq",    32'hFE000CE3, 32'd3,  32'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0);
        apply("lui",    32'h123450B7, 32'd4,  32'h12345000, 3'd3, 1'b0, 64'h0000000012345000, 3'd3, 1'b0);
        apply("bad7f",  32'h0000007F, 32'd5,  32'h0,        3'd7, 1'b1, 64'h0,                3'd7, 1'b1);
        apply("jal",    32'hFFDFF06F, 32'd6,  32'hFFFFFFFC, 3'd4, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd4, 1'b0);
        apply("csrwi",  32'h0002D073, 32'd7,  32'h5,        3'd5, 1'b0, 64'h5,                3'd5, 1'b0);
        apply("rvc",    32'h00000001, 32'd8,  32'h0,        3'd7, 1'b1, 64'h0,                3'd7, 1'b1);
        apply("add",    32'h002081B3, 32'd9,  32'h0,        3'd7, 1'b0, 64'h0,                3'd7, 1'b0);
        apply("slli",   32'h03F09093, 32'd10, 32'h1F,       3'd6, 1'b0, 64'h3F,               3'd6, 1'b0);
        apply("addiw",  32'h0000001B, 32'd11, 32'h0,        3'd7, 1'b1, 64'h0,                3'd0, 1'b0);
        apply("lw",     32'h00412083, 32'd12, 32'h4,        3'd0, 1'b0, 64'h4,                3'd0, 1'b0);
        apply("auipc",  32'h80000097, 32'd13, 32'h80000000, 3'd3, 1'b0, 64'hFFFFFFFF80000000, 3'd3, 1'b0);
        apply("addw",   32'h0000003B, 32'd14, 32'h0,        3'd7, 1'b1, 64'h0,                3'd7, 1'b0);

        in_valid = 1'b0;
        tick();
        chk("drain.out_valid", out_valid32, 0);
        chk("drain.count", count32, 0);
        chk("drain.imm", imm32, 0);
        chk("drain.type", type32, 0);
        chk("drain.tag", tag32, 0);

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'hFFF00093;
        in_tag    = 32'hA;
        tick();
        in_tag = 32'hB;
        tick();
        chk("full.count", count32, 2);
        chk("full.in_ready", in_ready32, 0);
        in_tag = 32'hC;
        tick();
        chk("full.no_push", count32, 2);
        chk("full.head", tag32, 32'hA);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("pop1.tag", tag32, 32'hB);
        chk("pop1.in_ready", in_ready32, 1);
        chk("pop1.count", count32, 1);
        tick();
        chk("pop2.out_valid", out_valid32, 0);

        // Simultaneous push/pop across pointer wrap
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 32'h100;
        tick();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_tag = 32'h100 + 32'(k);
            tick();
            chk("wrap.count", count32, 1);
            chk("wrap.tag", tag32, 32'h100 + 32'(k));
        end
        in_valid = 1'b0;
        tick();
        chk("wrap.empty", out_valid32, 0);

        // Flush with a simultaneous push while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 32'h20;
        tick();
        in_tag = 32'h21;
        tick();
        chk("flush.pre", count32, 2);
        flush  = 1'b1;
        in_tag = 32'h22;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.count", count32, 0);
        chk("flush.out_valid", out_valid32, 0);
        chk("flush.imm", imm32, 0);
        chk("flush.tag", tag32, 0);
        out_ready = 1'b1;
        tick();
        chk("flush.no_ghost", out_valid32, 0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 32'h30;
        tick();
        in_tag = 32'h31;
        tick();
        in_valid = 1'b0;
        chk("arst.pre", tag32, 32'h30);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out_valid", out_valid32, 0);
        chk("arst.imm", imm32, 0);
        chk("arst.tag", tag32, 0);
        chk("arst.count", count32, 0);
        chk("arst.in_ready", in_ready32, 1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("arst.after", out_valid32, 0);
        chk("arst.after64", out_valid64, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
